// File: rtl/sim_monitor_pkg.sv
// Shared types for the simulation monitor: FSM states and result status codes.
package sim_monitor_pkg;

    localparam int unsigned STATUS_W = 3;

    typedef enum logic [1:0] {
        st_hold = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_e;

    typedef enum logic [STATUS_W-1:0] {
        status_none    = 3'd0,
        status_pass    = 3'd1,
        status_fail    = 3'd2,
        status_timeout = 3'd3,
        status_halt    = 3'd4
    } status_e;

endpackage

// File: rtl/sim_halt_detect.sv
// Flags a CPU halt: HALT_WINDOW consecutive valid cycles with an unchanged pc.
// Only instantiated when SIM_MONITOR_HALT_DETECT_EN is defined.
module sim_halt_detect
    import sim_monitor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned HALT_WINDOW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pc_valid,
    output logic                  halt
);

    localparam int unsigned CNT_W = $clog2(HALT_WINDOW + 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] prev_q, prev_d;
    logic                  seen_q, seen_d;

    // The first valid pc of a run has nothing to differ from, so it counts as unchanged.
    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        seen_d = seen_q;
        if (!enable) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (pc_valid) begin
            seen_d = 1'b1;
            prev_d = pc;
            if (!seen_q || pc == prev_q) begin
                if (cnt_q != CNT_W'(HALT_WINDOW)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign halt = enable && (cnt_d == CNT_W'(HALT_WINDOW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            prev_q <= '0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/sim_monitor.sv
// Simulation monitor: holds the CPU in reset, watches for a result write, halt or timeout.
// Halt detection is built only when SIM_MONITOR_HALT_DETECT_EN is defined.
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 27,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           RESET_CYCLES = 4,
    parameter int unsigned           CYCLE_LIMIT  = 2560,
    parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR  = ADDR_WIDTH'(27'h7FFFFF0),
    parameter int unsigned           HALT_WINDOW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_data,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pc_valid,
    output logic                  cpu_reset,
    output logic                  running,
    output logic                  done,
    output logic [STATUS_W-1:0]   status,
    output logic [DATA_WIDTH-1:0] exit_code,
    output logic [31:0]           cycle_count
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [31:0]           count_q, count_d;
    status_e               status_q, status_d;
    logic [DATA_WIDTH-1:0] exit_q, exit_d;
    logic                  cpu_reset_d, running_d, done_d;
    logic                  result_hit, timeout_hit, halt;

`ifdef SIM_MONITOR_HALT_DETECT_EN
    sim_halt_detect #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HALT_WINDOW(HALT_WINDOW)
    ) u_halt_detect (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q == st_run),
        .pc      (pc),
        .pc_valid(pc_valid),
        .halt    (halt)
    );
`else
    logic unused_pc;
    assign unused_pc = ^{pc, pc_valid, HALT_WINDOW};
    assign halt      = 1'b0;
`endif

    assign result_hit  = bus_we && (bus_addr == RESULT_ADDR);
    assign timeout_hit = (count_q == 32'(CYCLE_LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= st_hold;
            hold_q    <= '0;
            count_q   <= '0;
            status_q  <= status_none;
            exit_q    <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            status_q  <= status_d;
            exit_q    <= exit_d;
            cpu_reset <= cpu_reset_d;
            running   <= running_d;
            done      <= done_d;
        end
    end

    // Completion priority: result write, then halt, then timeout.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        count_d  = count_q;
        status_d = status_q;
        exit_d   = exit_q;
        case (state_q)
            st_hold: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = st_run;
                    hold_d  = '0;
                    count_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            st_run: begin
                if (result_hit) begin
                    state_d  = st_done;
                    exit_d   = bus_data;
                    status_d = (bus_data == '0) ? status_pass : status_fail;
                end else if (halt) begin
                    state_d  = st_done;
                    status_d = status_halt;
                end else if (timeout_hit) begin
                    state_d  = st_done;
                    status_d = status_timeout;
                end else if (count_q != '1) begin
                    count_d = count_q + 32'd1;
                end
            end
            st_done: begin
                if (restart) begin
                    state_d  = st_hold;
                    hold_d   = '0;
                    count_d  = '0;
                    status_d = status_none;
                    exit_d   = '0;
                end
            end
            default: state_d = st_hold;
        endcase
    end

    always_comb begin
        cpu_reset_d = (state_d == st_hold);
        running_d   = (state_d == st_run);
        done_d      = (state_d == st_done);
    end

    assign status      = status_q;
    assign exit_code   = exit_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_sim_monitor.sv
// Scoreboarded random bench for sim_monitor; halt expectations follow SIM_MONITOR_HALT_DETECT_EN.
module tb_sim_monitor;

    localparam int          RC      = 4;
    localparam int          LIMIT   = 120;
    localparam int          HW      = 16;
    localparam int          NRUNS   = 14;
    localparam int          BIG     = 1 << 30;
    localparam logic [26:0] RA      = 27'h7FFFFF0;
    localparam logic [26:0] HALT_PC = 27'h05A5A00;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        bus_we;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic [26:0] pc;
    logic        pc_valid;
    logic        cpu_reset;
    logic        running;
    logic        done;
    logic [2:0]  status;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;

    sim_monitor #(
        .ADDR_WIDTH  (27),
        .DATA_WIDTH  (32),
        .RESET_CYCLES(RC),
        .CYCLE_LIMIT (LIMIT),
        .RESULT_ADDR (RA),
        .HALT_WINDOW (HW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .cpu_reset  (cpu_reset),
        .running    (running),
        .done       (done),
        .status     (status),
        .exit_code  (exit_code),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          write_at;
        logic [31:0] wdata;
        int          halt_at;
        int          restart_at;
        int          abort_at;
    } scen_t;

    typedef struct {
        logic [2:0]  status;
        logic [31:0] exit_code;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each completion source fires at a run cycle; earliest wins, ties by priority.
    function automatic exp_t predict(input scen_t s, output int end_cyc);
        exp_t r;
        int   tw, th, tt, e;
        tw = (s.write_at >= 0) ? s.write_at : BIG;
        th = BIG;
`ifdef SIM_MONITOR_HALT_DETECT_EN
        if (s.halt_at >= 0) th = (s.halt_at == 0) ? HW - 1 : s.halt_at + HW;
`endif
        tt = LIMIT - 1;
        e  = tw;
        if (th < e) e = th;
        if (tt < e) e = tt;
        r.count = 32'(e);
        if (tw == e) begin
            r.exit_code = s.wdata;
            r.status    = (s.wdata == 32'd0) ? 3'd1 : 3'd2;
        end else if (th == e) begin
            r.exit_code = 32'd0;
            r.status    = 3'd4;
        end else begin
            r.exit_code = 32'd0;
            r.status    = 3'd3;
        end
        end_cyc = e;
        return r;
    endfunction

    function automatic scen_t make_scen(input int r);
        scen_t s;
        s.write_at   = -1;
        s.wdata      = 32'd0;
        s.halt_at    = -1;
        s.restart_at = -1;
        s.abort_at   = -1;
        case (r)
            0: s.write_at = 100;
            1: begin s.write_at = 30; s.wdata = 32'h2A; s.restart_at = 10; end
            2: s.restart_at = LIMIT - 1;
            3: s.halt_at = 0;
            4: begin s.halt_at = 0; s.write_at = HW - 1; end
            5: begin s.write_at = 100; s.abort_at = 40; end
            default: begin
                s.write_at   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, LIMIT - 1));
                s.wdata      = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
                s.halt_at    = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, LIMIT - 1));
                s.restart_at = int'($urandom_range(0, LIMIT - 1));
                s.abort_at   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LIMIT - 1)) : -1;
            end
        endcase
        return s;
    endfunction

    task automatic drive_run(input scen_t s, input int k);
        logic [26:0] a;
        a = 27'($urandom);
        if (a == RA) a = a ^ 27'd1;
        if ($urandom_range(0, 1) == 0) a = RA + 27'd1;
        bus_addr = a;
        bus_data = $urandom;
        bus_we   = ($urandom_range(0, 3) == 0);
        if (k + 1 == s.write_at) begin
            bus_we   = 1'b1;
            bus_addr = RA + 27'd1;
            bus_data = 32'd0;
        end
        if (k == s.write_at) begin
            bus_we   = 1'b1;
            bus_addr = RA;
            bus_data = s.wdata;
        end
        restart = (k == s.restart_at);
        if (s.halt_at >= 0 && k >= s.halt_at) begin
            pc       = HALT_PC;
            pc_valid = 1'b1;
        end else begin
            pc       = 27'(k * 4);
            pc_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    // Entered in the first HOLD cycle; returns at the start of RUN cycle 0.
    task automatic hold_phase();
        for (int i = 0; i < RC; i++) begin
            bus_we   = 1'($urandom_range(0, 1));
            bus_addr = RA;
            bus_data = $urandom | 32'd1;
            restart  = 1'($urandom_range(0, 1));
            pc       = HALT_PC;
            pc_valid = 1'($urandom_range(0, 1));
            check("hold_flags", 64'({cpu_reset, running, done, status}), 64'(6'b100_000));
            check("hold_regs", 64'({exit_code, cycle_count}), 64'd0);
            @(posedge clk);
            #1;
        end
        restart = 1'b0;
        check("run_start_flags", 64'({cpu_reset, running, done}), 64'(3'b010));
        check("run_start_count", 64'(cycle_count), 64'd0);
    endtask

    task automatic finish_run(input exp_t e);
        check("done_flags", 64'({cpu_reset, running, done}), 64'(3'b001));
        for (int i = 0; i < 3; i++) begin
            bus_we   = 1'b1;
            bus_addr = (i == 0) ? RA : 27'($urandom);
            bus_data = $urandom | 32'd1;
            pc       = HALT_PC;
            pc_valid = 1'b1;
            restart  = 1'b0;
            @(posedge clk);
            #1;
            check("done_status_frozen", 64'(status), 64'(e.status));
            check("done_exit_frozen", 64'(exit_code), 64'(e.exit_code));
            check("done_count_frozen", 64'(cycle_count), 64'(e.count));
        end
        bus_we  = 1'b0;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        hold_phase();
    endtask

    task automatic do_abort();
        reset = 1'b1;
        #1;
        check("abort_flags", 64'({cpu_reset, running, done, status}), 64'(6'b100_000));
        check("abort_regs", 64'({exit_code, cycle_count}), 64'd0);
        bus_we   = 1'b1;
        bus_addr = RA;
        bus_data = 32'd0;
        @(posedge clk);
        #1;
        check("abort_held_flags", 64'({cpu_reset, running, done, status}), 64'(6'b100_000));
        @(negedge clk);
        reset  = 1'b0;
        bus_we = 1'b0;
        hold_phase();
    endtask

    // Stimulus: each run pushes its predicted completion before driving it.
    initial begin
        reset    = 1'b1;
        restart  = 1'b0;
        bus_we   = 1'b0;
        bus_addr = '0;
        bus_data = '0;
        pc       = '0;
        pc_valid = 1'b0;
        #2;
        check("reset_flags", 64'({cpu_reset, running, done, status}), 64'(6'b100_000));
        check("reset_regs", 64'({exit_code, cycle_count}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold_phase();
        for (int r = 0; r < NRUNS; r++) begin
            scen_t s;
            exp_t  e;
            int    end_cyc;
            bit    aborted;
            s       = make_scen(r);
            e       = predict(s, end_cyc);
            aborted = (s.abort_at >= 0) && (s.abort_at <= end_cyc);
            if (!aborted) sb.push_back(e);
            for (int k = 0; k <= end_cyc; k++) begin
                if (aborted && k == s.abort_at) break;
                check("run_state", 64'({running, done, cycle_count}), 64'({1'b1, 1'b0, 32'(k)}));
                drive_run(s, k);
                @(posedge clk);
                #1;
            end
            if (aborted) do_abort();
            else finish_run(e);
        end
        bus_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            check("one_hot", 64'($countones({cpu_reset, running, done})), 64'd1);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got status %0d, expected no completion", status);
                end else begin
                    e = sb.pop_front();
                    check("sb_status", 64'(status), 64'(e.status));
                    check("sb_exit_code", 64'(exit_code), 64'(e.exit_code));
                    check("sb_cycle_count", 64'(cycle_count), 64'(e.count));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
